pll_drp_responder: RTL and testbench

Responder (slave) end of the PLL DRP interface. It models the PLL's dynamic reconfiguration port and lock behaviour, so the DRP sequencer can be simulated and exercised in hardware without a real PLL primitive. Internally it holds a 2^ADDR_W x DATA_W register bank and answers DEN/DWE transactions with DRDY/DO after a fixed latency. It models LOCKED relative to the PLL reset input and flags protocol violations.

---
 rtl/pll_drp_pkg.sv | 13 +
 rtl/pll_drp_regbank.sv | 30 +++
 rtl/pll_drp_responder.sv | 142 ++++++++++++++
 tb/tb_pll_drp_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_drp_pkg.sv
// Shared DRP definitions for the PLL DRP responder and sequencer.
package pll_drp_pkg;

  localparam int unsigned DRP_ADDR_W = 5;
  localparam int unsigned DRP_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } drp_state_e;

endpackage

// File: rtl/pll_drp_regbank.sv
// DRP register bank: synchronous write, asynchronous read, cleared by reset.
module pll_drp_regbank
  import pll_drp_pkg::*;
#(
  parameter int unsigned ADDR_W = DRP_ADDR_W,
  parameter int unsigned DATA_W = DRP_DATA_W
) (
  input  logic              clk_sys_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_c = mem_q[addr_i];

endmodule

// File: rtl/pll_drp_responder.sv
// PLL DRP responder: register bank behind a fixed-latency DRP handshake,
// plus a lock model and sticky protocol-error flag.
module pll_drp_responder
  import pll_drp_pkg::*;
#(
  parameter int unsigned ADDR_W       = DRP_ADDR_W,
  parameter int unsigned DATA_W       = DRP_DATA_W,
  parameter int unsigned DRDY_LATENCY = 3,
  parameter int unsigned LOCK_DELAY   = 64
) (
  input  logic              clk_sys_i,
  input  logic              rst_n_i,
  input  logic              drp_den_i,
  input  logic              drp_dwe_i,
  input  logic [ADDR_W-1:0] drp_daddr_i,
  input  logic [DATA_W-1:0] drp_di_i,
  output logic [DATA_W-1:0] drp_do_o,
  output logic              drp_drdy_o,
  input  logic              pll_rst_i,
  output logic              pll_locked_o,
  output logic              err_o,
  input  logic              err_clr_i,
  output logic [7:0]        wr_count_o
);

  localparam int unsigned LAT_W  = 4;
  localparam int unsigned LOCK_W = 8;
  localparam int unsigned WCNT_W = 8;
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(DRDY_LATENCY - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_DELAY - 1);

  drp_state_e        state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic              commit_wr_c;
  logic              proto_err_c;
  logic [ADDR_W-1:0] bank_addr_c;
  logic [DATA_W-1:0] bank_rdata_c;
  logic [LOCK_W-1:0] lock_cnt_q;

  // State and request latch
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      lat_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      di_q    <= di_d;
    end
  end

  // Next state; DEN outside IDLE is dropped and flagged
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    addr_d      = addr_q;
    we_d        = we_q;
    di_d        = di_q;
    commit_wr_c = 1'b0;
    proto_err_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (drp_den_i) begin
          addr_d = drp_daddr_i;
          we_d   = drp_dwe_i;
          di_d   = drp_di_i;
          if (DRDY_LATENCY == 1) begin
            state_d = RESP;
          end else begin
            lat_d   = LAT_LOAD;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        proto_err_c = drp_den_i;
        lat_d       = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) state_d = RESP;
      end
      RESP: begin
        proto_err_c = drp_den_i;
        commit_wr_c = we_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single bank port: new request address in IDLE, latched address otherwise
  assign bank_addr_c = (state_q == IDLE) ? drp_daddr_i : addr_q;

  pll_drp_regbank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_regbank (
    .clk_sys_i (clk_sys_i),
    .rst_n_i   (rst_n_i),
    .we_i      (commit_wr_c),
    .addr_i    (bank_addr_c),
    .wdata_i   (di_q),
    .rdata_c   (bank_rdata_c)
  );

  // Response, write counter and sticky error; read data is captured before the write lands
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drp_drdy_o <= 1'b0;
      drp_do_o   <= '0;
      wr_count_o <= '0;
      err_o      <= 1'b0;
    end else begin
      drp_drdy_o <= (state_d == RESP);
      if (state_d == RESP) drp_do_o <= bank_rdata_c;
      if (commit_wr_c) wr_count_o <= wr_count_o + WCNT_W'(1);
      if (proto_err_c || (commit_wr_c && !pll_rst_i)) err_o <= 1'b1;
      else if (err_clr_i)                             err_o <= 1'b0;
    end
  end

  // Lock model: a write without PLL reset is treated as losing lock
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_cnt_q   <= '0;
      pll_locked_o <= 1'b0;
    end else if (pll_rst_i || commit_wr_c) begin
      lock_cnt_q   <= '0;
      pll_locked_o <= 1'b0;
    end else if (!pll_locked_o) begin
      if (lock_cnt_q == LOCK_LAST) pll_locked_o <= 1'b1;
      else                         lock_cnt_q   <= lock_cnt_q + LOCK_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_drp_responder.sv
// Bench for pll_drp_responder: directed literal checks plus randomized traffic
// compared every cycle against a timing-level reference model.
module tb_pll_drp_responder;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 16;
  localparam int unsigned LAT   = 3;
  localparam int unsigned LOCKD = 64;

  logic          clk_sys_i = 1'b0;
  logic          rst_n_i   = 1'b0;
  logic          den       = 1'b0;
  logic          dwe       = 1'b0;
  logic [AW-1:0] daddr     = '0;
  logic [DW-1:0] di        = '0;
  logic          pll_rst   = 1'b1;
  logic          err_clr   = 1'b0;
  logic [DW-1:0] do_w;
  logic          drdy, locked, err;
  logic [7:0]    wrc;

  always #5 clk_sys_i = ~clk_sys_i;

  pll_drp_responder #(
    .ADDR_W (AW), .DATA_W (DW), .DRDY_LATENCY (LAT), .LOCK_DELAY (LOCKD)
  ) dut (
    .clk_sys_i    (clk_sys_i),
    .rst_n_i      (rst_n_i),
    .drp_den_i    (den),
    .drp_dwe_i    (dwe),
    .drp_daddr_i  (daddr),
    .drp_di_i     (di),
    .drp_do_o     (do_w),
    .drp_drdy_o   (drdy),
    .pll_rst_i    (pll_rst),
    .pll_locked_o (locked),
    .err_o        (err),
    .err_clr_i    (err_clr),
    .wr_count_o   (wrc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model, expressed in terms of edge numbers rather than states
  logic [DW-1:0] m_bank [2**AW];
  int            cyc        = 0;
  int            busy_until = 0;
  bit            pend       = 0;
  int            pend_due   = 0;
  logic [AW-1:0] pend_addr  = '0;
  bit            pend_we    = 0;
  logic [DW-1:0] pend_di    = '0;
  bit            cmt        = 0;
  int            cmt_at     = 0;
  logic [AW-1:0] cmt_addr   = '0;
  logic [DW-1:0] cmt_di     = '0;
  bit            exp_drdy   = 0;
  logic [DW-1:0] exp_do     = '0;
  bit            exp_err    = 0;
  bit            exp_locked = 0;
  int            exp_wrc    = 0;
  int            low_run    = 0;
  bit            set_err, wr_now;

  always @(posedge clk_sys_i) begin
    cyc++;
    if (!rst_n_i) begin
      foreach (m_bank[i]) m_bank[i] = '0;
      busy_until = cyc; pend = 0; cmt = 0;
      exp_drdy = 0; exp_do = '0; exp_err = 0; exp_locked = 0; exp_wrc = 0; low_run = 0;
    end else begin
      set_err = 0;
      wr_now  = 0;
      if (cmt && cmt_at == cyc) begin
        cmt = 0;
        m_bank[cmt_addr] = cmt_di;
        exp_wrc = (exp_wrc + 1) % 256;
        wr_now = 1;
      end
      if (den) begin
        if (cyc <= busy_until) set_err = 1;
        else begin
          pend = 1; pend_due = cyc + LAT - 1; busy_until = cyc + LAT;
          pend_addr = daddr; pend_we = dwe; pend_di = di;
        end
      end
      exp_drdy = 0;
      if (pend && pend_due == cyc) begin
        exp_drdy = 1;
        exp_do   = m_bank[pend_addr];
        pend     = 0;
        if (pend_we) begin
          cmt = 1; cmt_at = cyc + 1; cmt_addr = pend_addr; cmt_di = pend_di;
        end
      end
      if (wr_now && !pll_rst) set_err = 1;
      if (set_err)      exp_err = 1;
      else if (err_clr) exp_err = 0;
      if (pll_rst || wr_now) begin
        low_run = 0; exp_locked = 0;
      end else if (!exp_locked) begin
        low_run++;
        if (low_run >= LOCKD) exp_locked = 1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(posedge clk_sys_i) begin
    #1;
    check("m_drdy",   32'(drdy),   32'(exp_drdy));
    check("m_do",     32'(do_w),   32'(exp_do));
    check("m_err",    32'(err),    32'(exp_err));
    check("m_locked", 32'(locked), 32'(exp_locked));
    check("m_wrc",    32'(wrc),    32'(exp_wrc));
  end

  task automatic txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW-1:0] exp_d, input string nm);
    @(negedge clk_sys_i);
    den = 1'b1; dwe = we; daddr = a; di = d;
    for (int i = 1; i <= int'(LAT); i++) begin
      @(posedge clk_sys_i); #1;
      if (i == 1) begin den = 1'b0; dwe = 1'b0; end
      check({nm, "_drdy"}, 32'(drdy), 32'(i == int'(LAT)));
      if (i == int'(LAT)) check({nm, "_do"}, 32'(do_w), 32'(exp_d));
    end
    @(posedge clk_sys_i); #1;
    check({nm, "_drdy_end"}, 32'(drdy), 32'd0);
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    while (n < 300) begin
      @(posedge clk_sys_i); #1;
      n++;
      if (locked) break;
    end
  endtask

  int pulses;
  int n;

  initial begin
    repeat (3) @(posedge clk_sys_i);
    #1;
    check("rst_drdy",   32'(drdy),   32'd0);
    check("rst_do",     32'(do_w),   32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err",    32'(err),    32'd0);
    check("rst_wrc",    32'(wrc),    32'd0);
    @(negedge clk_sys_i) rst_n_i = 1'b1;

    txn(1'b0, 5'h08, 16'h0000, 16'h0000, "rd08_init");
    txn(1'b1, 5'h08, 16'h1234, 16'h0000, "wr08");
    txn(1'b0, 5'h08, 16'h0000, 16'h1234, "rd08");
    check("wrc_after_wr", 32'(wrc), 32'd1);
    check("err_clean",    32'(err), 32'd0);

    // Second DEN one cycle after an accepted one
    @(negedge clk_sys_i); den = 1'b1; dwe = 1'b0; daddr = 5'h08;
    @(negedge clk_sys_i); dwe = 1'b1; di = 16'hDEAD;
    @(negedge clk_sys_i); den = 1'b0; dwe = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk_sys_i); #1;
      pulses += int'(drdy);
    end
    check("overlap_pulses", 32'(pulses), 32'd1);
    check("overlap_err",    32'(err),    32'd1);
    txn(1'b0, 5'h08, 16'h0000, 16'h1234, "rd08_overlap");
    check("wrc_overlap", 32'(wrc), 32'd1);
    check("err_sticky",  32'(err), 32'd1);
    @(negedge clk_sys_i) err_clr = 1'b1;
    @(posedge clk_sys_i); #1;
    check("err_cleared", 32'(err), 32'd0);
    @(negedge clk_sys_i) err_clr = 1'b0;

    // Lock timing
    repeat (5) @(negedge clk_sys_i);
    pll_rst = 1'b0;
    wait_lock(n);
    check("lock_delay", 32'(n), 32'd64);
    @(negedge clk_sys_i) pll_rst = 1'b1;
    @(posedge clk_sys_i); #1;
    check("unlock_on_rst", 32'(locked), 32'd0);
    @(negedge clk_sys_i) pll_rst = 1'b0;
    wait_lock(n);
    check("relock", 32'(n), 32'd64);

    // Write while locked and out of PLL reset
    txn(1'b1, 5'h14, 16'hBEEF, 16'h0000, "wr14_locked");
    check("wr14_unlock", 32'(locked), 32'd0);
    check("wr14_err",    32'(err),    32'd1);
    check("wr14_wrc",    32'(wrc),    32'd2);
    wait_lock(n);
    check("relock_after_wr", 32'(n), 32'd64);
    txn(1'b0, 5'h14, 16'h0000, 16'hBEEF, "rd14");

    // Reset in the middle of a write
    @(negedge clk_sys_i); pll_rst = 1'b1; den = 1'b1; dwe = 1'b1; daddr = 5'h03; di = 16'h5555;
    @(posedge clk_sys_i); #1; den = 1'b0; dwe = 1'b0;
    @(negedge clk_sys_i) rst_n_i = 1'b0;
    repeat (3) begin
      @(posedge clk_sys_i); #1;
      check("midrst_no_drdy", 32'(drdy), 32'd0);
    end
    @(negedge clk_sys_i) rst_n_i = 1'b1;
    repeat (3) begin
      @(posedge clk_sys_i); #1;
      check("postrst_no_drdy", 32'(drdy), 32'd0);
    end
    txn(1'b0, 5'h03, 16'h0000, 16'h0000, "rd03_after_rst");
    txn(1'b0, 5'h08, 16'h0000, 16'h0000, "rd08_cleared");
    check("wrc_after_rst", 32'(wrc), 32'd0);

    // Randomized traffic
    repeat (3000) begin
      @(negedge clk_sys_i);
      den     = ($urandom_range(2) == 0);
      dwe     = 1'($urandom);
      daddr   = AW'($urandom);
      di      = DW'($urandom);
      err_clr = ($urandom_range(15) == 0);
      if ($urandom_range(99) == 0) pll_rst = ~pll_rst;
      rst_n_i = ($urandom_range(499) != 0);
    end
    @(negedge clk_sys_i);
    den = 1'b0; dwe = 1'b0; err_clr = 1'b0; rst_n_i = 1'b1;
    repeat (5) @(posedge clk_sys_i);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
